motor_pwm_mmio: RTL and testbench
=================================

Name: motor_pwm_mmio

Overview:
- Memory-mapped motor-drive peripheral on the sys_bus GPIO slave slot. That slot currently has gpio_rdata tied to 0 and gpio_wen unconnected; this block replaces that stub.
- Consumes CPU D-bus load/store traffic and produces two H-bridge PWM channels (left/right wheel).
- Decodes two quadrature wheel encoders into signed position counters.
- Includes a command watchdog that coasts the motors if firmware stops refreshing commands.

Parameters:
PERIOD_DEFAULT, 2499, reset value of PERIOD. Gives 20 kHz PWM at 50 MHz.
WDT_CYCLES, 5000000, watchdog timeout in clk cycles (100 ms at 50 MHz).
CNT_W, 16, width of PWM counter, PERIOD and DUTY registers.

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous active-high reset
bus_sel  in  1  sys_bus decode: current access targets this slave
bus_valid  in  1  CPU D-bus access valid
bus_wen  in  1  write strobe (store)
bus_addr  in  32  byte address; only [4:2] decoded
bus_wdata  in  32  store data
bus_wmask  in  4  byte enables
bus_rdata  out  32  read data, combinational
bus_ready  out  1  access complete
mot_a_in1  out  1  channel A H-bridge input 1
mot_a_in2  out  1  channel A H-bridge input 2
mot_b_in1  out  1  channel B H-bridge input 1
mot_b_in2  out  1  channel B H-bridge input 2
enc_a_pha / enc_a_phb  in  1 each  channel A encoder phases (asynchronous)
enc_b_pha / enc_b_phb  in  1 each  channel B encoder phases (asynchronous)

Behaviour:
- Reset values: one clock; reset is asynchronous and active-high. All outputs are 0 in reset and immediately after it.
- Register reset values: PERIOD=PERIOD_DEFAULT; all other registers 0; shadows 0; watchdog counter = WDT_CYCLES.
- Bus handshake:
  - bus_ready = bus_valid & bus_sel. Zero wait states; the CPU never stalls on this slave.
  - bus_rdata = selected register when bus_sel, else 0. Unmapped bits read 0.
  - A write commits on the clk edge where bus_valid & bus_sel & bus_wen. Each byte is gated by bus_wmask.
- Register map (offset = bus_addr[4:2]*4):
  - 0x00 CTRL: b0 EN, b1 BRAKE, b2 WDT_EN, b3 ENC_CLR. ENC_CLR is write-1 self-clearing and always reads 0.
  - 0x04 PERIOD [CNT_W-1:0].
  - 0x08 DUTY_A [CNT_W-1:0].
  - 0x0C DUTY_B [CNT_W-1:0].
  - 0x10 DIR: b0 channel A reverse, b1 channel B reverse.
  - 0x14 ENC_A: signed 32-bit, read-only.
  - 0x18 ENC_B: signed 32-bit, read-only.
  - 0x1C STATUS: b0 WDT_TRIP (W1C), b1 ENC_ERR (W1C), b2 RUN (RO) = EN & !WDT_TRIP.
- PWM generation:
  - Free-running counter 0..period_sh, wrapping to 0 after reaching period_sh.
  - period_sh, duty_a_sh and duty_b_sh load from their registers on the wrap cycle, or every cycle while RUN=0. This keeps the duty glitch-free mid-period.
  - pwm_x = (cnt < duty_x_sh). DUTY=0 gives constant 0; DUTY > PERIOD gives constant 1.
  - The counter holds at 0 while RUN=0.
- Output mapping, registered, 1 cycle after counter compare:
  - RUN=0: in1=in2=0 (coast).
  - RUN & BRAKE: in1=in2=1.
  - RUN, DIR=0: in1=pwm, in2=0.
  - RUN, DIR=1: in1=0, in2=pwm.
  - in1 and in2 are never both 1 except in brake.
  - A DIR change takes effect at the next wrap, via a shadowed DIR.
- Watchdog:
  - Any write to DUTY_A, DUTY_B or DIR reloads the counter to WDT_CYCLES.
  - While WDT_EN & EN, the counter decrements each cycle. On reaching 0 it sets WDT_TRIP, which holds the motors in coast.
  - WDT_TRIP stays set until W1C. Clearing it also reloads the counter.
  - A reload and a W1C in the same cycle are both honoured.
- Encoders:
  - Each phase uses a 2-FF synchronizer plus a previous-state register.
  - x4 quadrature decode: 00→01→11→10→00 counts +1; the reverse sequence counts -1.
  - A transition where both bits change is illegal: no count change, and ENC_ERR is set.
  - Counters wrap in two's complement.
  - ENC_CLR zeroes both counters that cycle. A count event on the same cycle is discarded.
- Simultaneous events: a set condition on WDT_TRIP or ENC_ERR in the same cycle as a W1C write wins; the bit stays 1.
- Reset mid-operation forces coast outputs immediately, asynchronously.

Test Plan:
- Reset, read all 8 registers -> PERIOD=2499, all others 0; all mot_* outputs 0.
- PERIOD=99, DUTY_A=25, EN=1 -> mot_a_in1 high 25 of every 100 cycles, mot_a_in2=0. DUTY_A=0 gives flat 0; DUTY_A=200 gives flat 1.
- Write DUTY_A=50 mid-period (cnt=10) -> high time of the current period is unchanged; the next period is 50 high. Set DIR b0=1 -> in1/in2 swap at the wrap; no cycle with both high.
- WDT_CYCLES=1000, WDT_EN=EN=1, no refresh -> STATUS=0x1 at cycle 1000, outputs coast. W1C STATUS=1 plus a DUTY write -> RUN=1, PWM resumes.
- Drive enc_a 00,01,11,10,00 ×3 -> ENC_A=12. Drive reverse ×1 -> 8. Apply 00→11 -> ENC_A unchanged, STATUS b1=1. ENC_CLR -> ENC_A=0.
- SB 0x5A to DUTY_B byte1 (wmask=0010) with DUTY_B=0x1234 -> DUTY_B=0x5A34; bus_ready=1 same cycle.

Source files
------------

// File: rtl/motor_pwm_mmio_if.sv
// sys_bus slave-slot signals between the CPU D-bus decode and a peripheral.
interface motor_pwm_mmio_if;
  logic        bus_sel;
  logic        bus_valid;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_sel, bus_valid, bus_wen, bus_addr, bus_wdata, bus_wmask,
    input  bus_rdata, bus_ready
  );
  modport slave (
    input  bus_sel, bus_valid, bus_wen, bus_addr, bus_wdata, bus_wmask,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/motor_pwm_mmio.sv
// Motor-drive MMIO peripheral: two H-bridge PWM channels, two quadrature
// encoder counters and a command watchdog, on a zero-wait-state slave slot.
module motor_pwm_mmio #(
  parameter int unsigned PERIOD_DEFAULT = 2499,
  parameter int unsigned WDT_CYCLES     = 5000000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic            clk,
  input  logic            rst,
  motor_pwm_mmio_if.slave bus,
  output logic            mot_a_in1,
  output logic            mot_a_in2,
  output logic            mot_b_in1,
  output logic            mot_b_in2,
  input  logic            enc_a_pha,
  input  logic            enc_a_phb,
  input  logic            enc_b_pha,
  input  logic            enc_b_phb
);
  localparam logic [2:0] A_CTRL = 3'd0, A_PERIOD = 3'd1, A_DUTYA = 3'd2, A_DUTYB = 3'd3,
                         A_DIR  = 3'd4, A_ENCA   = 3'd5, A_ENCB  = 3'd6, A_STAT  = 3'd7;

  logic             en_q, brake_q, wdt_en_q;
  logic [CNT_W-1:0] period_q, duty_a_q, duty_b_q;
  logic [1:0]       dir_q;
  logic             trip_q, trip_d, err_q, err_d;
  logic [31:0]      wdt_q, wdt_d;
  logic [1:0][31:0] enc_q, enc_d;
  logic [1:0][1:0]  ph_raw, s1_q, s2_q, pv_q, step;
  logic [1:0]       inc, dec, bad;
  logic [CNT_W-1:0] cnt_q, period_sh_q, duty_a_sh_q, duty_b_sh_q;
  logic [1:0]       dir_sh_q, pwm, in1_q, in2_q;
  logic             run, wrap, load_sh, wdt_act, trip_set;
  logic [2:0]       ra;
  logic [31:0]      wm, rmux, merged;
  logic [7:0]       wsel;
  logic             wr, enc_clr, trip_clr, err_clr, wdt_reload;
  logic             unused_addr;

  assign ra          = bus.bus_addr[4:2];
  assign unused_addr = ^{bus.bus_addr[31:5], bus.bus_addr[1:0]};
  assign run         = en_q & ~trip_q;

  // Register readback; also the "old value" that unmasked write bytes keep
  always_comb begin
    rmux = '0;
    case (ra)
      A_CTRL:   rmux = {29'd0, wdt_en_q, brake_q, en_q};
      A_PERIOD: rmux = 32'(period_q);
      A_DUTYA:  rmux = 32'(duty_a_q);
      A_DUTYB:  rmux = 32'(duty_b_q);
      A_DIR:    rmux = {30'd0, dir_q};
      A_ENCA:   rmux = enc_q[0];
      A_ENCB:   rmux = enc_q[1];
      A_STAT:   rmux = {29'd0, run, err_q, trip_q};
      default:  rmux = '0;
    endcase
  end

  assign bus.bus_rdata = bus.bus_sel ? rmux : '0;
  assign bus.bus_ready = bus.bus_valid & bus.bus_sel;

  assign wr     = bus.bus_valid & bus.bus_sel & bus.bus_wen;
  assign wsel   = wr ? (8'd1 << ra) : 8'd0;
  assign wm     = {{8{bus.bus_wmask[3]}}, {8{bus.bus_wmask[2]}},
                   {8{bus.bus_wmask[1]}}, {8{bus.bus_wmask[0]}}};
  assign merged = (rmux & ~wm) | (bus.bus_wdata & wm);

  // CTRL readback bit 3 is 0, so merged[3] is exactly a written 1
  assign enc_clr    = wsel[A_CTRL] & merged[3];
  assign trip_clr   = wsel[A_STAT] & wm[0] & bus.bus_wdata[0];
  assign err_clr    = wsel[A_STAT] & wm[1] & bus.bus_wdata[1];
  assign wdt_reload = wsel[A_DUTYA] | wsel[A_DUTYB] | wsel[A_DIR] | trip_clr;

  // Bus-writable configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {wdt_en_q, brake_q, en_q} <= '0;
      period_q <= CNT_W'(PERIOD_DEFAULT);
      duty_a_q <= '0;
      duty_b_q <= '0;
      dir_q    <= '0;
    end else begin
      if (wsel[A_CTRL])   {wdt_en_q, brake_q, en_q} <= merged[2:0];
      if (wsel[A_PERIOD]) period_q <= merged[CNT_W-1:0];
      if (wsel[A_DUTYA])  duty_a_q <= merged[CNT_W-1:0];
      if (wsel[A_DUTYB])  duty_b_q <= merged[CNT_W-1:0];
      if (wsel[A_DIR])    dir_q    <= merged[1:0];
    end
  end

  // Watchdog: refresh on command writes, trip when the countdown expires
  assign wdt_act  = wdt_en_q & en_q;
  assign trip_set = wdt_act & ~wdt_reload & (wdt_q == 32'd1);
  always_comb begin
    wdt_d = wdt_q;
    if (wdt_reload)                   wdt_d = WDT_CYCLES;
    else if (wdt_act && wdt_q != '0)  wdt_d = wdt_q - 32'd1;
    trip_d = trip_set | (trip_q & ~trip_clr);
  end

  // Quadrature decode: map Gray phase {a,b} to a 2-bit position, diff mod 4
  assign ph_raw = {{enc_b_pha, enc_b_phb}, {enc_a_pha, enc_a_phb}};
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      step[c] = {s2_q[c][1], ^s2_q[c]} - {pv_q[c][1], ^pv_q[c]};
      inc[c]  = (step[c] == 2'd1);
      dec[c]  = (step[c] == 2'd3);
      bad[c]  = (step[c] == 2'd2);
      enc_d[c] = enc_q[c];
      if (enc_clr)     enc_d[c] = '0;
      else if (inc[c]) enc_d[c] = enc_q[c] + 32'd1;
      else if (dec[c]) enc_d[c] = enc_q[c] - 32'd1;
    end
    err_d = (|bad) | (err_q & ~err_clr);
  end

  // Status, watchdog counter, encoder synchronizers and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trip_q <= 1'b0;
      err_q  <= 1'b0;
      wdt_q  <= WDT_CYCLES;
      s1_q   <= '0;
      s2_q   <= '0;
      pv_q   <= '0;
      enc_q  <= '0;
    end else begin
      trip_q <= trip_d;
      err_q  <= err_d;
      wdt_q  <= wdt_d;
      s1_q   <= ph_raw;
      s2_q   <= s1_q;
      pv_q   <= s2_q;
      enc_q  <= enc_d;
    end
  end

  // PWM counter and shadows; shadows track live values while stopped
  assign wrap    = (cnt_q == period_sh_q);
  assign load_sh = ~run | wrap;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      period_sh_q <= '0;
      duty_a_sh_q <= '0;
      duty_b_sh_q <= '0;
      dir_sh_q    <= '0;
    end else begin
      cnt_q <= load_sh ? '0 : cnt_q + CNT_W'(1);
      if (load_sh) begin
        period_sh_q <= period_q;
        duty_a_sh_q <= duty_a_q;
        duty_b_sh_q <= duty_b_q;
        dir_sh_q    <= dir_q;
      end
    end
  end

  assign pwm = {cnt_q < duty_b_sh_q, cnt_q < duty_a_sh_q};

  // H-bridge drive: coast when stopped, brake overrides, else PWM on one leg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in1_q <= '0;
      in2_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        in1_q[c] <= run & (brake_q | (~dir_sh_q[c] & pwm[c]));
        in2_q[c] <= run & (brake_q | ( dir_sh_q[c] & pwm[c]));
      end
    end
  end

  assign mot_a_in1 = in1_q[0];
  assign mot_a_in2 = in2_q[0];
  assign mot_b_in1 = in1_q[1];
  assign mot_b_in2 = in2_q[1];
endmodule

// File: tb/tb_motor_pwm_mmio.sv
// Scoreboarded bench for motor_pwm_mmio: bus reads are predicted by a
// register-level model and checked by an independent bus monitor; PWM
// behaviour is checked by counting high cycles over whole periods.
module tb_motor_pwm_mmio;
  localparam int P_DEF = 2499;
  localparam int WDT   = 1000;
  localparam logic [2:0] CTRL = 0, PER = 1, DA = 2, DB = 3, DIR = 4, ENA = 5, ENB = 6, STAT = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  motor_pwm_mmio_if bus_if ();
  logic a1, a2, b1, b2;
  logic [1:0][1:0] ph = '0;

  motor_pwm_mmio #(.PERIOD_DEFAULT(P_DEF), .WDT_CYCLES(WDT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .mot_a_in1(a1), .mot_a_in2(a2), .mot_b_in1(b1), .mot_b_in2(b2),
    .enc_a_pha(ph[0][1]), .enc_a_phb(ph[0][0]),
    .enc_b_pha(ph[1][1]), .enc_b_phb(ph[1][0])
  );

  int n_cmp = 0, n_err = 0;
  int viol = 0;
  bit excl_chk = 1'b1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_reg [5];
  int          m_enc [2];
  bit          m_trip, m_err;
  logic [1:0]  gray  [4];
  int          ph_idx[2];

  function automatic void model_reset();
    m_reg[0] = 0; m_reg[1] = P_DEF; m_reg[2] = 0; m_reg[3] = 0; m_reg[4] = 0;
    m_enc[0] = 0; m_enc[1] = 0; m_trip = 0; m_err = 0;
  endfunction

  function automatic logic [31:0] field_mask(input logic [2:0] a);
    if (a == CTRL) return 32'h7;
    if (a == DIR)  return 32'h3;
    return 32'hFFFF;
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] bm;
    for (int i = 0; i < 4; i++) bm[8*i +: 8] = m[i] ? 8'hFF : 8'h00;
    if (a <= DIR) m_reg[a] = ((m_reg[a] & ~bm) | (d & bm)) & field_mask(a);
    if (a == CTRL && m[0] && d[3]) begin m_enc[0] = 0; m_enc[1] = 0; end
    if (a == STAT && m[0]) begin
      if (d[0]) m_trip = 0;
      if (d[1]) m_err = 0;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    if (a <= DIR) return m_reg[a];
    if (a == ENA) return 32'(m_enc[0]);
    if (a == ENB) return 32'(m_enc[1]);
    return {29'd0, m_reg[0][0] & ~m_trip, m_err, m_trip};
  endfunction

  function automatic int pw_high(input int d, input int p);
    return (d > p + 1) ? p + 1 : d;
  endfunction

  // ---------------- scoreboard + monitor ----------------
  typedef struct { logic [2:0] a; logic [31:0] exp; } rd_t;
  rd_t sb_q[$];

  initial begin
    bus_if.bus_valid = 0; bus_if.bus_sel = 0; bus_if.bus_wen = 0;
    bus_if.bus_addr = 0; bus_if.bus_wdata = 0; bus_if.bus_wmask = 0;
  end

  initial forever begin
    @(negedge clk);
    if (bus_if.bus_valid) begin
      check("ready", {31'd0, bus_if.bus_ready}, {31'd0, bus_if.bus_sel});
      if (!bus_if.bus_sel) check("rdata_unsel", bus_if.bus_rdata, 32'd0);
      else if (!bus_if.bus_wen) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_empty: read seen with rdata 0x%0h, no prediction queued", bus_if.bus_rdata);
        end else begin
          rd_t r;
          r = sb_q.pop_front();
          check($sformatf("rd[%0d]", r.a), bus_if.bus_rdata, r.exp);
        end
      end
    end
    if (excl_chk && ((a1 && a2) || (b1 && b2))) viol++;
  end

  // ---------------- stimulus tasks ----------------
  task automatic bus_cyc(input bit sel, input bit wen, input logic [2:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    rd_t e;
    r = $urandom();
    @(posedge clk); #1;
    bus_if.bus_valid = 1'b1; bus_if.bus_sel = sel; bus_if.bus_wen = wen;
    bus_if.bus_addr = {r[31:5], a, r[1:0]}; bus_if.bus_wdata = d; bus_if.bus_wmask = m;
    if (sel && !wen) begin
      e.a = a; e.exp = model_read(a);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus_if.bus_valid = 1'b0; bus_if.bus_sel = 1'b0; bus_if.bus_wen = 1'b0;
    if (sel && wen) model_write(a, d, m);
  endtask

  task automatic bwr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_cyc(1'b1, 1'b1, a, d, m);
  endtask

  task automatic brd(input logic [2:0] a);
    bus_cyc(1'b1, 1'b0, a, $urandom(), 4'hF);
  endtask

  // dir: +1 forward, -1 reverse, 2 = illegal double-bit change
  task automatic enc_step(input int c, input int dir);
    ph_idx[c] = (ph_idx[c] + dir + 4) % 4;
    if (dir == 2) m_err = 1;
    else          m_enc[c] += dir;
    @(posedge clk); #1;
    ph[c] = gray[ph_idx[c]];
    repeat (3) @(posedge clk);
  endtask

  int w_a1, w_a2, w_b1, w_b2;
  task automatic count_win(input int n);
    w_a1 = 0; w_a2 = 0; w_b1 = 0; w_b2 = 0;
    repeat (n) begin
      @(negedge clk);
      w_a1 += int'(a1); w_a2 += int'(a2); w_b1 += int'(b1); w_b2 += int'(b2);
    end
  endtask

  task automatic wait_rise_a1(output bit ok);
    logic prev;
    ok = 1'b0;
    prev = a1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (a1 && !prev) ok = 1'b1;
      prev = a1;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    int h0, h1, h2, da, db, dr;
    logic [2:0] ra;
    logic [31:0] rd_d;
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    ph_idx[0] = 0; ph_idx[1] = 0;
    model_reset();

    #2 check("in_reset_out", {28'd0, a1, a2, b1, b2}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("post_reset_out", {28'd0, a1, a2, b1, b2}, 32'd0);
    for (int i = 0; i < 8; i++) brd(3'(i));

    // unselected accesses: no ready, rdata 0, no write commit
    bus_cyc(1'b0, 1'b0, PER, 0, 4'hF);
    bus_cyc(1'b0, 1'b1, DA, 32'h77, 4'hF);
    brd(DA);

    // byte-lane write
    bwr(DB, 32'h1234, 4'hF);
    bwr(DB, 32'h5A5A5A5A, 4'b0010);
    brd(DB);

    // randomized register traffic with EN and ENC_CLR kept off
    for (int i = 0; i < 30; i++) begin
      ra = 3'($urandom_range(0, 4));
      rd_d = $urandom();
      if (ra == CTRL) rd_d &= ~32'h9;
      bwr(ra, rd_d, 4'($urandom_range(0, 15)));
      brd(ra);
      brd(3'($urandom_range(0, 7)));
    end

    // PWM basics, period 100 cycles
    bwr(PER, 99, 4'hF); bwr(DIR, 0, 4'hF); bwr(DB, 0, 4'hF);
    bwr(DA, 25, 4'hF); bwr(CTRL, 1, 4'hF);
    repeat (150) @(posedge clk);
    count_win(100);
    check("pwm25_in1", w_a1, pw_high(25, 99));
    check("pwm25_in2", w_a2, 0);
    bwr(DA, 0, 4'hF);   repeat (150) @(posedge clk); count_win(100);
    check("pwm0_in1", w_a1, 0);
    bwr(DA, 200, 4'hF); repeat (150) @(posedge clk); count_win(100);
    check("pwm200_in1", w_a1, 100);

    // duty update mid-period only takes effect at the next wrap
    bwr(DA, 25, 4'hF);
    repeat (150) @(posedge clk);
    wait_rise_a1(ok);
    check("rise_midp", ok, 1);
    h0 = 1; h1 = 0;
    fork
      for (int i = 1; i < 200; i++) begin
        @(negedge clk);
        if (a1) begin if (i < 100) h0++; else h1++; end
      end
      begin repeat (9) @(posedge clk); bwr(DA, 50, 4'hF); end
    join
    check("midp_cur", h0, 25);
    check("midp_next", h1, 50);

    // DIR change mid-period swaps legs at the wrap
    wait_rise_a1(ok);
    check("rise_dir", ok, 1);
    h0 = 1; h1 = 0; h2 = 0;
    fork
      for (int i = 1; i < 200; i++) begin
        @(negedge clk);
        if (i < 100) h0 += int'(a1);
        else begin h1 += int'(a1); h2 += int'(a2); end
      end
      begin repeat (9) @(posedge clk); bwr(DIR, 1, 4'hF); end
    join
    check("dir_cur_in1", h0, 50);
    check("dir_next_in1", h1, 0);
    check("dir_next_in2", h2, 50);

    // randomized duty/direction on both channels
    for (int k = 0; k < 4; k++) begin
      da = $urandom_range(0, 150); db = $urandom_range(0, 150); dr = $urandom_range(0, 3);
      bwr(DA, da, 4'hF); bwr(DB, db, 4'hF); bwr(DIR, dr, 4'hF);
      repeat (250) @(posedge clk);
      count_win(100);
      check("rnd_a1", w_a1, dr[0] ? 0 : pw_high(da, 99));
      check("rnd_a2", w_a2, dr[0] ? pw_high(da, 99) : 0);
      check("rnd_b1", w_b1, dr[1] ? 0 : pw_high(db, 99));
      check("rnd_b2", w_b2, dr[1] ? pw_high(db, 99) : 0);
    end

    // brake drives both legs high; coast drives both low
    excl_chk = 1'b0;
    bwr(CTRL, 3, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk) check("brake", {28'd0, a1, a2, b1, b2}, 32'hF);
    bwr(CTRL, 0, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk) check("coast", {28'd0, a1, a2, b1, b2}, 32'h0);
    excl_chk = 1'b1;

    // watchdog expiry and recovery
    bwr(DIR, 0, 4'hF); bwr(DB, 0, 4'hF); bwr(DA, 25, 4'hF);
    bwr(CTRL, 5, 4'hF);
    repeat (WDT - 10) @(posedge clk);
    brd(STAT);
    repeat (20) @(posedge clk);
    m_trip = 1;
    brd(STAT);
    count_win(100);
    check("wdt_coast", w_a1 + w_a2 + w_b1 + w_b2, 0);
    bwr(STAT, 32'h1, 4'h1);
    bwr(DA, 25, 4'hF);
    brd(STAT);
    repeat (150) @(posedge clk);
    count_win(100);
    check("wdt_resume", w_a1, 25);
    bwr(CTRL, 0, 4'hF);

    // encoders
    for (int i = 0; i < 12; i++) enc_step(0, 1);
    brd(ENA);
    for (int i = 0; i < 4; i++) enc_step(0, -1);
    brd(ENA);
    for (int i = 0; i < 20; i++) enc_step(1, ($urandom_range(0, 2) == 0) ? 1 : -1);
    brd(ENB);
    for (int i = 0; i < 4; i++) enc_step(1, -1);
    brd(ENB);
    enc_step(0, 2);
    brd(ENA);
    brd(STAT);
    bwr(STAT, 32'h2, 4'h1);
    brd(STAT);
    bwr(CTRL, 32'h8, 4'h1);
    brd(ENA); brd(ENB); brd(CTRL);

    // asynchronous reset mid-run
    bwr(DA, 200, 4'hF); bwr(CTRL, 1, 4'hF);
    repeat (150) @(posedge clk);
    @(posedge clk); #3;
    check("pre_rst_in1", {31'd0, a1}, 32'd1);
    rst = 1'b1;
    #1 check("async_rst_out", {28'd0, a1, a2, b1, b2}, 32'd0);
    ph = '0; ph_idx[0] = 0; ph_idx[1] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) brd(3'(i));

    repeat (3) @(posedge clk);
    check("both_high", viol, 0);
    check("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard time bound
  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time bound, %0d compared", n_cmp);
    $fatal(1);
  end
endmodule
